// File: rtl/ftoi_arb_pkg.sv
// Shared constants, float32 layout and the out-of-range test for the ftoi arbiter.
// The resp_ovf flag is built only when FTOI_ARB_OVF_EN is defined.
package ftoi_arb_pkg;

  localparam int FLOAT_W  = 32;
  localparam int INT_W    = 32;
  localparam int EXP_BIAS = 127;
  localparam int MAN_W    = 23;

  localparam logic [7:0]         EXP_OVF          = 8'd158;
  localparam logic [7:0]         EXP_INT          = 8'(EXP_BIAS + MAN_W);
  localparam logic [FLOAT_W-1:0] INT_MIN_AS_FLOAT = 32'hCF000000;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] man;
  } float32_t;

  // -2^31 is the only operand with exp >= 158 that still fits in int32.
  function automatic logic float_ovf(input logic [FLOAT_W-1:0] f);
    float32_t v;
    v = f;
    return (v.exp == 8'hFF) || ((v.exp >= EXP_OVF) && (f != INT_MIN_AS_FLOAT));
  endfunction

endpackage

// File: rtl/ftoi.sv
// Combinational float32 -> int32, round half away from zero.
// Zero/denormal inputs give 0; out-of-range inputs wrap to the low 32 bits of the magnitude.
module ftoi
  import ftoi_arb_pkg::*;
(
  input  logic [FLOAT_W-1:0] f,
  output logic [INT_W-1:0]   i
);

  float32_t    fv;
  logic [63:0] mant;
  logic [63:0] mag;
  logic [7:0]  sh;

  always_comb begin
    fv   = f;
    mant = {40'd0, 1'b1, fv.man};
    sh   = 8'd0;
    mag  = '0;
    if (fv.exp == 8'd0) begin
      mag = '0;
    end else if (fv.exp >= EXP_INT) begin
      mag = mant << (fv.exp - EXP_INT);
    end else begin
      // Adding half an LSB of the result before truncating rounds ties up in magnitude.
      sh  = EXP_INT - fv.exp;
      mag = (mant + (64'd1 << (sh - 8'd1))) >> sh;
    end
    i = fv.sign ? (~mag[INT_W-1:0] + 32'd1) : mag[INT_W-1:0];
  end

endmodule

// File: rtl/ftoi_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible index after the pointer, modulo NREQ.
// The pointer follows the last grant; reset puts it at NREQ-1 so index 0 wins first.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] eligible,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_vld
);

  logic [IW-1:0] ptr;
  int            k;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    k         = 0;
    for (int j = 1; j <= NREQ; j++) begin
      k = (int'(ptr) + j) % NREQ;
      if (!grant_vld && eligible[IW'(k)]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(k);
      end
    end
    grant = grant_vld ? (NREQ'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn)          ptr <= IW'(NREQ - 1);
    else if (grant_vld) ptr <= grant_idx;
  end

endmodule

// File: rtl/ftoi_arbiter.sv
// Shares one ftoi converter among NREQ requesters with round-robin grant and a
// 1-entry result buffer per requester. Define FTOI_ARB_OVF_EN to add resp_ovf.
module ftoi_arbiter
  import ftoi_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*FLOAT_W-1:0] req_data,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [NREQ*INT_W-1:0]   resp_data
`ifdef FTOI_ARB_OVF_EN
  ,
  output logic [NREQ-1:0]         resp_ovf
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0][FLOAT_W-1:0] req_vec;
  logic [NREQ-1:0][INT_W-1:0]   data_q;
  logic [NREQ-1:0]              valid_q;
  logic [NREQ-1:0]              eligible;
  logic [NREQ-1:0]              grant;
  logic [IW-1:0]                grant_idx;
  logic                         grant_vld;
  logic [FLOAT_W-1:0]           operand;
  logic [INT_W-1:0]             conv;

  assign req_vec = req_data;

  // A full buffer being drained this cycle can accept a new result.
  assign eligible = req_valid & (~valid_q | resp_ready) & {NREQ{rstn}};

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .eligible  (eligible),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign req_ready = grant;
  assign operand   = grant_vld ? req_vec[grant_idx] : '0;

  ftoi u_ftoi (
    .f (operand),
    .i (conv)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      for (int l = 0; l < NREQ; l++) begin
        if (grant[l]) begin
          valid_q[l] <= 1'b1;
          data_q[l]  <= conv;
        end else if (resp_ready[l]) begin
          valid_q[l] <= 1'b0;
        end
      end
    end
  end

  assign resp_valid = valid_q;
  assign resp_data  = data_q;

`ifdef FTOI_ARB_OVF_EN
  logic            ovf_now;
  logic [NREQ-1:0] ovf_q;

  assign ovf_now = float_ovf(operand);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_q <= '0;
    end else begin
      for (int l = 0; l < NREQ; l++)
        if (grant[l]) ovf_q[l] <= ovf_now;
    end
  end

  assign resp_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ftoi_arbiter.sv
// Bench for ftoi_arbiter (NREQ=2): real-arithmetic conversion model plus a
// per-cycle grant/buffer scoreboard, driven by directed vectors.
module tb_ftoi_arbiter;

  localparam int NREQ = 2;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_data = '0;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready = '1;
  logic [NREQ*32-1:0]   resp_data;
`ifdef FTOI_ARB_OVF_EN
  logic [NREQ-1:0]      resp_ovf;
`endif

  int n_vec = 0;
  int n_bad = 0;

  ftoi_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
`ifdef FTOI_ARB_OVF_EN
    ,
    .resp_ovf   (resp_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Float32 widened to a double, then rounded half away from zero in real arithmetic.
  function automatic logic [31:0] model_ftoi(input logic [31:0] f);
    logic [63:0] d;
    real         r;
    longint      q;
    int          e;
    e = int'(f[30:23]);
    if (e == 0) return 32'd0;
    d = {f[31], 11'(e - 127 + 1023), f[22:0], 29'd0};
    r = $bitstoreal(d);
    if (r >= 0.0) r = $floor(r + 0.5);
    else          r = -$floor(-r + 0.5);
    q = longint'(r);
    return q[31:0];
  endfunction

  function automatic bit in_range(input logic [31:0] f);
    return (f[30:23] < 8'd158) || (f == 32'hCF000000);
  endfunction

  function automatic logic model_ovf(input logic [31:0] f);
    return (f[30:23] == 8'hFF) || ((f[30:23] >= 8'd158) && (f != 32'hCF000000));
  endfunction

  function automatic logic [31:0] rd(input int i);
    return resp_data[32*i +: 32];
  endfunction

  // Scoreboard: expected grant from eligibility and pointer, expected buffer contents.
  logic [NREQ-1:0] m_valid = '0;
  logic [31:0]     m_data [NREQ];
  logic            m_ovf  [NREQ];
  bit              m_known[NREQ];
  int              m_ptr = NREQ - 1;
  logic [NREQ-1:0] exp_grant = '0;

  always @(negedge clk) begin : cmp
    int k;
    exp_grant = '0;
    if (rstn) begin
      for (int j = 1; j <= NREQ; j++) begin
        k = (m_ptr + j) % NREQ;
        if (exp_grant == '0 && req_valid[k] && (!m_valid[k] || resp_ready[k]))
          exp_grant[k] = 1'b1;
      end
    end
    check("cyc req_ready", 32'(req_ready), 32'(exp_grant));
    check("cyc resp_valid", 32'(resp_valid), 32'(m_valid));
    for (int i = 0; i < NREQ; i++) begin
      if (m_valid[i] && m_known[i]) check("cyc resp_data", rd(i), m_data[i]);
`ifdef FTOI_ARB_OVF_EN
      if (m_valid[i]) check("cyc resp_ovf", 32'(resp_ovf[i]), 32'(m_ovf[i]));
`endif
    end
  end

  always @(posedge clk) begin
    if (!rstn) begin
      m_valid = '0;
      m_ptr   = NREQ - 1;
      for (int i = 0; i < NREQ; i++) begin
        m_data[i] = '0; m_ovf[i] = 1'b0; m_known[i] = 1'b1;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (exp_grant[i]) begin
          m_valid[i] = 1'b1;
          m_data[i]  = model_ftoi(req_data[32*i +: 32]);
          m_known[i] = in_range(req_data[32*i +: 32]);
          m_ovf[i]   = model_ovf(req_data[32*i +: 32]);
          m_ptr      = i;
        end else if (resp_ready[i]) begin
          m_valid[i] = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; req_valid = '0;
    step(); step();
    rstn = 1'b1;
  endtask

  task automatic one(input int i, input logic [31:0] f, input logic [31:0] exp_r, input string nm);
    req_valid[i] = 1'b1; req_data[32*i +: 32] = f; #1;
    check({nm, " ready"}, 32'(req_ready), 32'(1) << i);
    step(); req_valid[i] = 1'b0; #1;
    check({nm, " valid"}, 32'(resp_valid[i]), 32'd1);
    check({nm, " data"}, rd(i), exp_r);
    step();
  endtask

`ifdef FTOI_ARB_OVF_EN
  task automatic ovf_one(input logic [31:0] f, input logic exp_o, input string nm);
    req_valid[0] = 1'b1; req_data[31:0] = f;
    step(); req_valid[0] = 1'b0; #1;
    check({nm, " ovf"}, 32'(resp_ovf[0]), 32'(exp_o));
    step();
  endtask
`endif

  initial begin
    // Pin the model against hand-computed values.
    check("model 2.5",   model_ftoi(32'h40200000), 32'd3);
    check("model -2.5",  model_ftoi(32'hC0200000), 32'hFFFFFFFD);
    check("model 0.5",   model_ftoi(32'h3F000000), 32'd1);
    check("model <0.5",  model_ftoi(32'h3EFFFFFF), 32'd0);
    check("model -0.75", model_ftoi(32'hBF400000), 32'hFFFFFFFF);
    check("model -2^31", model_ftoi(32'hCF000000), 32'h80000000);

    // Reset: no grant while rstn is low even with requests pending.
    req_valid = 2'b11; req_data = {32'h40000000, 32'h3F800000};
    step(); #1;
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_data", 32'(resp_data[31:0] | resp_data[63:32]), 32'd0);
    do_reset();

    one(0, 32'h40200000, 32'd3,        "r0 2.5");
    one(1, 32'hC0200000, 32'hFFFFFFFD, "r1 -2.5");
    one(1, 32'h3F000000, 32'd1,        "r1 0.5");
    one(1, 32'h00000000, 32'd0,        "r1 zero");
    one(0, 32'h3FC00000, 32'd2,        "r0 1.5");
    one(0, 32'hBF400000, 32'hFFFFFFFF, "r0 -0.75");
    one(1, 32'h00400000, 32'd0,        "r1 denorm");

    // Contention straight after reset: 0 first, then alternate.
    do_reset();
    req_data = {32'h40000000, 32'h3F800000}; req_valid = 2'b11; #1;
    check("cont first grant", 32'(req_ready), 32'b01);
    for (int c = 0; c < 4; c++) begin
      step();
      check("cont ready", 32'(req_ready), (c % 2 == 0) ? 32'b10 : 32'b01);
      check("cont valid", 32'(resp_valid), (c % 2 == 0) ? 32'b01 : 32'b10);
      check("cont data", rd((c % 2 == 0) ? 0 : 1), (c % 2 == 0) ? 32'd1 : 32'd2);
    end

    // Backpressure on consumer 0.
    req_valid = '0; step(); step();
    resp_ready = 2'b10;
    req_valid = 2'b01; req_data[31:0] = 32'h40400000; #1;
    check("bp fill ready", 32'(req_ready), 32'b01);
    step();
    req_data = {32'h40A00000, 32'h40800000}; req_valid = 2'b11; #1;
    check("bp blocked ready", 32'(req_ready), 32'b10);
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp ready", 32'(req_ready), 32'b10);
      check("bp valid", 32'(resp_valid), 32'b11);
      check("bp hold data0", rd(0), 32'd3);
      check("bp data1", rd(1), 32'd5);
    end
    resp_ready = 2'b11; #1;
    check("bp drain+grant ready", 32'(req_ready), 32'b01);
    step();
    check("bp drain+grant valid", 32'(resp_valid[0]), 32'd1);
    check("bp drain+grant data", rd(0), 32'd4);

    // Reset with buffer 0 full.
    resp_ready = 2'b00; rstn = 1'b0; #1;
    check("midrst ready", 32'(req_ready), 32'd0);
    step();
    check("midrst valid", 32'(resp_valid), 32'd0);
    step();
    rstn = 1'b1; resp_ready = 2'b11; #1;
    check("midrst first grant", 32'(req_ready), 32'b01);
    step();
    check("midrst data0", rd(0), 32'd4);
    req_valid = '0; step(); step();

`ifdef FTOI_ARB_OVF_EN
    ovf_one(32'h4F000000, 1'b1, "ovf 2^31");
    ovf_one(32'hCF000000, 1'b0, "ovf -2^31");
    req_valid[0] = 1'b1; req_data[31:0] = 32'hCF000000;
    step(); req_valid[0] = 1'b0; #1;
    check("ovf -2^31 data", rd(0), 32'h80000000);
    step();
    ovf_one(32'h7FC00000, 1'b1, "ovf nan");
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
